// File: rtl/turn_signal_pkg.sv
// Shared types and default constants for the turn-signal flasher.
package turn_signal_pkg;

    // Flasher FSM states; the encoding is exported on flash_state for debug.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StTurnL  = 3'd1,
        StTurnR  = 3'd2,
        StTapL   = 3'd3,
        StTapR   = 3'd4,
        StHazard = 3'd5
    } flash_state_e;

    localparam int unsigned DefDebounceCycles = 20000;
    localparam int unsigned DefHalfPeriod     = 2500000;
    localparam int unsigned DefTapCycles      = 5000000;
    localparam int unsigned DefComfortFlashes = 3;

    // True when the state drives the left lamp set.
    function automatic logic lamp_left(input flash_state_e s);
        return (s == StTurnL) || (s == StTapL) || (s == StHazard);
    endfunction

    // True when the state drives the right lamp set.
    function automatic logic lamp_right(input flash_state_e s);
        return (s == StTurnR) || (s == StTapR) || (s == StHazard);
    endfunction

endpackage

// File: rtl/turn_signal_flasher_if.sv
// Switch inputs and lamp/click outputs of the turn-signal flasher.
interface turn_signal_flasher_if;
    logic       sw_turn_l;
    logic       sw_turn_r;
    logic       sw_hazard;
    logic       turn_left;
    logic       turn_right;
    logic       click;
    logic [2:0] flash_state;

    // Master owns the raw switches and observes the lamps.
    modport master (
        output sw_turn_l, sw_turn_r, sw_hazard,
        input  turn_left, turn_right, click, flash_state
    );

    // Slave (the flasher) reads the switches and drives the lamps.
    modport slave (
        input  sw_turn_l, sw_turn_r, sw_hazard,
        output turn_left, turn_right, click, flash_state
    );
endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a consecutive-disagreement debouncer.
module switch_debounce
    import turn_signal_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic deb_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Count disagreeing cycles; flip on the last one, any agreeing cycle clears the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntLast) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/turn_signal_flasher.sv
// Turn-signal flasher: debounced lever/hazard arbitration, blink generation,
// comfort (lane-change) sequence on a short lever tap, and piezo click.
module turn_signal_flasher
    import turn_signal_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned HALF_PERIOD     = DefHalfPeriod,
    parameter int unsigned TAP_CYCLES      = DefTapCycles,
    parameter int unsigned COMFORT_FLASHES = DefComfortFlashes
) (
    input logic                  clk,
    input logic                  rst,
    turn_signal_flasher_if.slave bus
);

    localparam int unsigned HalfW  = $clog2(HALF_PERIOD + 1);
    localparam int unsigned HoldW  = $clog2(TAP_CYCLES + 1);
    localparam int unsigned FlashW = $clog2(COMFORT_FLASHES + 1);

    localparam logic [HalfW-1:0]  HalfLast = HalfW'(HALF_PERIOD - 1);
    localparam logic [HoldW-1:0]  HoldMax  = HoldW'(TAP_CYCLES);
    localparam logic [FlashW-1:0] FlashMax = FlashW'(COMFORT_FLASHES);

    logic deb_l, deb_r, deb_hazard;
    logic req_hz, req_l, req_r;

    flash_state_e      state_q, state_d;
    logic [HalfW-1:0]  half_cnt_q, half_cnt_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
    logic              phase_q, phase_d;
    logic              turn_left_q, turn_left_d;
    logic              turn_right_q, turn_right_d;
    logic              click_q, click_d;

    logic half_wrap, tap_done, short_hold, restart, enter_turn, stay_turn;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
        .clk   (clk),
        .rst   (rst),
        .raw_i (bus.sw_turn_l),
        .deb_o (deb_l)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
        .clk   (clk),
        .rst   (rst),
        .raw_i (bus.sw_turn_r),
        .deb_o (deb_r)
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_hz (
        .clk   (clk),
        .rst   (rst),
        .raw_i (bus.sw_hazard),
        .deb_o (deb_hazard)
    );

    // Both levers at once cancel each other rather than picking a side.
    assign req_hz = deb_hazard;
    assign req_l  = deb_l & ~deb_r;
    assign req_r  = deb_r & ~deb_l;

    assign half_wrap  = (half_cnt_q == HalfLast);
    assign tap_done   = half_wrap & ~phase_q & (flash_cnt_q == FlashMax);
    assign short_hold = (hold_cnt_q < HoldMax) && (flash_cnt_q < FlashMax);

    // Next-state arbitration: hazard beats lever beats everything else.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_hz)     state_d = StHazard;
                else if (req_l) state_d = StTurnL;
                else if (req_r) state_d = StTurnR;
            end
            StTurnL: begin
                if (req_hz)      state_d = StHazard;
                else if (req_r)  state_d = StTurnR;
                else if (!req_l) state_d = short_hold ? StTapL : StIdle;
            end
            StTurnR: begin
                if (req_hz)      state_d = StHazard;
                else if (req_l)  state_d = StTurnL;
                else if (!req_r) state_d = short_hold ? StTapR : StIdle;
            end
            StTapL, StTapR: begin
                if (req_hz)        state_d = StHazard;
                else if (req_l)    state_d = StTurnL;
                else if (req_r)    state_d = StTurnR;
                else if (tap_done) state_d = StIdle;
            end
            StHazard: begin
                if (!req_hz) begin
                    if (req_l)      state_d = StTurnL;
                    else if (req_r) state_d = StTurnR;
                    else            state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A tap continues the lamp set already blinking, so it is the only change that keeps phase.
    assign restart = (state_d != StIdle) && (state_d != state_q) &&
                     !((state_q == StTurnL) && (state_d == StTapL)) &&
                     !((state_q == StTurnR) && (state_d == StTapR));
    assign enter_turn = ((state_d == StTurnL) || (state_d == StTurnR)) && (state_d != state_q);
    assign stay_turn  = ((state_q == StTurnL) || (state_q == StTurnR)) && (state_d == state_q);

    // Blink phase, click, hold and flash counters, and the lamp levels for the next cycle.
    always_comb begin
        half_cnt_d  = half_cnt_q;
        phase_d     = phase_q;
        hold_cnt_d  = hold_cnt_q;
        flash_cnt_d = flash_cnt_q;
        click_d     = 1'b0;

        if (state_d == StIdle) begin
            half_cnt_d = '0;
            phase_d    = 1'b0;
        end else if (restart) begin
            half_cnt_d = '0;
            phase_d    = 1'b1;
            click_d    = 1'b1;
        end else if (half_wrap) begin
            half_cnt_d = '0;
            phase_d    = ~phase_q;
            click_d    = 1'b1;
            if (phase_q && (flash_cnt_q != FlashMax)) flash_cnt_d = flash_cnt_q + 1'b1;
        end else begin
            half_cnt_d = half_cnt_q + 1'b1;
        end

        if (enter_turn) begin
            hold_cnt_d  = '0;
            flash_cnt_d = '0;
        end else if (stay_turn && (hold_cnt_q != HoldMax)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        turn_left_d  = phase_d & lamp_left(state_d);
        turn_right_d = phase_d & lamp_right(state_d);
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            half_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            flash_cnt_q  <= '0;
            phase_q      <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
            click_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            flash_cnt_q  <= flash_cnt_d;
            phase_q      <= phase_d;
            turn_left_q  <= turn_left_d;
            turn_right_q <= turn_right_d;
            click_q      <= click_d;
        end
    end

    assign bus.turn_left   = turn_left_q;
    assign bus.turn_right  = turn_right_q;
    assign bus.click       = click_q;
    assign bus.flash_state = state_q;

endmodule

// File: tb/tb_turn_signal_flasher.sv
// Directed self-checking bench for turn_signal_flasher with short test parameters.
module tb_turn_signal_flasher;

    localparam logic [2:0] SIdle   = 3'd0;
    localparam logic [2:0] STurnL  = 3'd1;
    localparam logic [2:0] STurnR  = 3'd2;
    localparam logic [2:0] STapL   = 3'd3;
    localparam logic [2:0] STapR   = 3'd4;
    localparam logic [2:0] SHazard = 3'd5;

    // Raw change after edge 0 -> sync edges 1,2 -> debounce flips edge 6 -> state/lamp edge 7.
    localparam int Lat = 7;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    turn_signal_flasher_if bus ();

    turn_signal_flasher #(
        .DEBOUNCE_CYCLES (4),
        .HALF_PERIOD     (10),
        .TAP_CYCLES      (30),
        .COMFORT_FLASHES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Blink level k cycles after (re)entering an active state.
    function automatic logic on_at(input int k);
        return ((k / 10) % 2) == 0;
    endfunction

    function automatic logic click_at(input int k);
        return (k % 10) == 0;
    endfunction

    function automatic logic [5:0] observed();
        return {bus.flash_state, bus.turn_left, bus.turn_right, bus.click};
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        bus.sw_turn_l = 1'b0;
        bus.sw_turn_r = 1'b0;
        bus.sw_hazard = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst           = 1'b1;
        bus.sw_turn_l = 1'b1;
        bus.sw_turn_r = 1'b0;
        bus.sw_hazard = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step();
            obs = observed();
            checks++;
            if (obs !== 6'b0) begin
                fails++;
                $display("FAIL reset_hold n=%0d: got %b expected %b", n, obs, 6'b0);
            end
        end
        bus.sw_turn_l = 1'b0;
        bus.sw_hazard = 1'b0;
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            obs = observed();
            checks++;
            if (obs !== 6'b0) begin
                fails++;
                $display("FAIL reset_release n=%0d: got %b expected %b", n, obs, 6'b0);
            end
        end
    endtask

    task automatic test_hold_left();
        logic [5:0] obs, exp;
        int k;
        do_reset();
        bus.sw_turn_l = 1'b1;
        for (int n = 1; n <= Lat + 199; n++) begin
            step();
            k = n - Lat;
            exp = (n < Lat) ? 6'b0 : {STurnL, on_at(k), 1'b0, click_at(k)};
            obs = observed();
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL hold_left n=%0d: got %b expected %b", n, obs, exp);
            end
        end
        bus.sw_turn_l = 1'b0;
    endtask

    task automatic test_tap_right();
        logic [5:0] obs, exp;
        logic [2:0] st;
        logic       prev_r;
        int k, rises;
        do_reset();
        rises  = 0;
        prev_r = 1'b0;
        bus.sw_turn_r = 1'b1;
        for (int n = 1; n <= 90; n++) begin
            step();
            if (n == 15) bus.sw_turn_r = 1'b0;
            k = n - Lat;
            if (n < Lat)       st = SIdle;
            else if (n < 22)   st = STurnR;
            else if (n < 67)   st = STapR;
            else               st = SIdle;
            exp = (st == SIdle) ? 6'b0 : {st, 1'b0, on_at(k), click_at(k)};
            obs = observed();
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL tap_right n=%0d: got %b expected %b", n, obs, exp);
            end
            if (bus.turn_right && !prev_r) rises++;
            prev_r = bus.turn_right;
        end
        checks++;
        if (rises !== 3) begin
            fails++;
            $display("FAIL tap_right_flash_count: got %0d expected %0d", rises, 3);
        end
    endtask

    task automatic test_long_hold();
        logic [5:0] obs, exp;
        int k;
        do_reset();
        bus.sw_turn_l = 1'b1;
        for (int n = 1; n <= 110; n++) begin
            step();
            if (n == 50) bus.sw_turn_l = 1'b0;
            k = n - Lat;
            exp = (n < Lat || n >= 57) ? 6'b0 : {STurnL, on_at(k), 1'b0, click_at(k)};
            obs = observed();
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL long_hold n=%0d: got %b expected %b", n, obs, exp);
            end
        end
    endtask

    task automatic test_hazard_override();
        logic [5:0] obs, exp;
        int k;
        do_reset();
        bus.sw_turn_l = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == 11) bus.sw_hazard = 1'b1;
            if (n == 30) bus.sw_hazard = 1'b0;
            if (n < Lat) begin
                exp = 6'b0;
            end else if (n < 18) begin
                k = n - Lat;
                exp = {STurnL, on_at(k), 1'b0, click_at(k)};
            end else if (n < 37) begin
                k = n - 18;
                exp = {SHazard, on_at(k), on_at(k), click_at(k)};
            end else begin
                k = n - 37;
                exp = {STurnL, on_at(k), 1'b0, click_at(k)};
            end
            obs = observed();
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL hazard_override n=%0d: got %b expected %b", n, obs, exp);
            end
        end
        bus.sw_turn_l = 1'b0;
    endtask

    task automatic test_both_levers_glitch();
        logic [5:0] obs, exp;
        int k;
        do_reset();
        bus.sw_turn_l = 1'b1;
        bus.sw_turn_r = 1'b1;
        for (int n = 1; n <= 55; n++) begin
            step();
            if (n == 20) bus.sw_hazard = 1'b1;
            if (n == 23) bus.sw_hazard = 1'b0;
            if (n == 40) bus.sw_turn_r = 1'b0;
            k = n - 47;
            exp = (n < 47) ? 6'b0 : {STurnL, on_at(k), 1'b0, click_at(k)};
            obs = observed();
            checks++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL both_levers_glitch n=%0d: got %b expected %b", n, obs, exp);
            end
        end
        bus.sw_turn_l = 1'b0;
    endtask

    task automatic test_reset_mid_tap();
        logic [5:0] obs, exp;
        do_reset();
        bus.sw_turn_l = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (n == 15) bus.sw_turn_l = 1'b0;
        end
        // n=30 is 23 cycles after entry: TAP_L, second ON half.
        exp = {STapL, 1'b1, 1'b0, 1'b0};
        obs = observed();
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL tap_left_before_reset: got %b expected %b", obs, exp);
        end
        #2;
        rst = 1'b1;
        #1;
        obs = observed();
        checks++;
        if (obs !== 6'b0) begin
            fails++;
            $display("FAIL async_reset_drop: got %b expected %b", obs, 6'b0);
        end
        step();
        step();
        rst = 1'b0;
        for (int n = 0; n < 80; n++) begin
            step();
            obs = observed();
            checks++;
            if (obs !== 6'b0) begin
                fails++;
                $display("FAIL after_reset_idle n=%0d: got %b expected %b", n, obs, 6'b0);
            end
        end
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.sw_turn_l = 1'b0;
        bus.sw_turn_r = 1'b0;
        bus.sw_hazard = 1'b0;
        test_reset();
        test_hold_left();
        test_tap_right();
        test_long_hold();
        test_hazard_override();
        test_both_levers_glitch();
        test_reset_mid_tap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
